// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - instruction-memory read handshake between fetch unit and memory
interface inst_fetch_unit_if #(
    parameter int WORD_SIZE = 16
);
    logic                 readM;
    logic [WORD_SIZE-1:0] address;
    logic [WORD_SIZE-1:0] i_data;
    logic                 inputReady;

    modport master (
        output readM,
        output address,
        input  i_data,
        input  inputReady
    );

    modport slave (
        input  readM,
        input  address,
        output i_data,
        output inputReady
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch stage: PC, instruction-memory handshake, next-PC select, retire counter
module inst_fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_fetch_unit_if.master     mem,
    output logic [WORD_SIZE-1:0]  inst,
    output logic                  inst_valid,
    output logic [WORD_SIZE-1:0]  pc,
    input  logic                  advance,
    input  logic                  jump,
    input  logic [11:0]           jump_target,
    input  logic                  branch_taken,
    input  logic [7:0]            branch_offset,
    output logic [WORD_SIZE-1:0]  num_inst
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] inst_q, inst_d;
    logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;
    logic                 readm_q, readm_d;
    logic                 inst_valid_q, inst_valid_d;
    logic [WORD_SIZE-1:0] pc_seq;
    logic [WORD_SIZE-1:0] next_pc;

    assign pc_seq = pc_q + 1'b1;

    always_comb begin
        if (jump) begin
            next_pc = {pc_q[WORD_SIZE-1:12], jump_target};
        end else if (branch_taken) begin
            next_pc = pc_seq + {{(WORD_SIZE-8){branch_offset[7]}}, branch_offset};
        end else begin
            next_pc = pc_seq;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        num_inst_d = num_inst_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (mem.inputReady) begin
                    inst_d  = mem.i_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (advance) begin
                    pc_d       = next_pc;
                    num_inst_d = num_inst_q + 1'b1;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        // Status flags are registered from the next state so they track state_q exactly.
        readm_d      = (state_d == FETCH);
        inst_valid_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            num_inst_q   <= '0;
            readm_q      <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            num_inst_q   <= num_inst_d;
            readm_q      <= readm_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign mem.readM   = readm_q;
    assign mem.address = pc_q;
    assign inst        = inst_q;
    assign inst_valid  = inst_valid_q;
    assign pc          = pc_q;
    assign num_inst    = num_inst_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] pc;
    logic        advance;
    logic        jump;
    logic [11:0] jump_target;
    logic        branch_taken;
    logic [7:0]  branch_offset;
    logic [15:0] num_inst;

    inst_fetch_unit_if #(.WORD_SIZE(16)) m ();

    inst_fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem           (m.master),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .pc            (pc),
        .advance       (advance),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .num_inst      (num_inst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
        logic [15:0] num;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] last_inst = 16'h0000;
    logic [15:0] num_model = 16'h0000;
    logic [15:0] p;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] addr, input logic [15:0] data, input int waits);
        int n = 0;
        while (!m.readM && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_readM", {15'd0, m.readM}, 16'd1);
        chk("fetch_addr", m.address, addr);
        for (int w = 0; w < waits; w++) begin
            m.inputReady = 1'b0;
            m.i_data     = 16'hDEAD ^ 16'(w);
            tick();
            chk("wait_readM", {15'd0, m.readM}, 16'd1);
            chk("wait_addr", m.address, addr);
            chk("wait_inst", inst, last_inst);
        end
        m.i_data     = data;
        m.inputReady = 1'b1;
        exp_q.push_back('{inst: data, pc: addr, num: num_model});
        tick();
        m.inputReady = 1'b0;
        m.i_data     = 16'hDEAD;
        last_inst    = data;
        chk("issue_readM", {15'd0, m.readM}, 16'd0);
        chk("issue_valid", {15'd0, inst_valid}, 16'd1);
    endtask

    task automatic retire(input logic j, input logic [11:0] tgt, input logic br,
                          input logic [7:0] off, input logic [15:0] exp_pc);
        advance       = 1'b1;
        jump          = j;
        jump_target   = tgt;
        branch_taken  = br;
        branch_offset = off;
        tick();
        advance       = 1'b0;
        jump          = 1'b0;
        branch_taken  = 1'b0;
        num_model     = num_model + 16'd1;
        chk("retire_valid", {15'd0, inst_valid}, 16'd0);
        chk("retire_readM", {15'd0, m.readM}, 16'd1);
        chk("retire_pc", pc, exp_pc);
        chk("retire_num", num_inst, num_model);
    endtask

    // Monitor: compare the scoreboard head each time a new instruction is presented.
    initial begin : monitor
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (inst_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected", inst, 16'hXXXX);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_inst", inst, e.inst);
                    chk("mon_pc", pc, e.pc);
                    chk("mon_num", num_inst, e.num);
                end
            end
            prev_valid = inst_valid;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset         = 1'b1;
        advance       = 1'b0;
        jump          = 1'b0;
        jump_target   = 12'h000;
        branch_taken  = 1'b0;
        branch_offset = 8'h00;
        m.i_data      = 16'h0000;
        m.inputReady  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_readM", {15'd0, m.readM}, 16'd0);
        chk("rst_valid", {15'd0, inst_valid}, 16'd0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_inst", inst, 16'h0000);
        chk("rst_num", num_inst, 16'h0000);
        tick();
        chk("first_readM", {15'd0, m.readM}, 16'd1);

        fetch(16'h0000, 16'hF01C, 0);
        retire(1'b1, 12'h005, 1'b0, 8'h00, 16'h0005);
        fetch(16'h0005, 16'h1111, 0);
        retire(1'b0, 12'h000, 1'b0, 8'h00, 16'h0006);
        fetch(16'h0006, 16'h2222, 3);
        retire(1'b1, 12'h020, 1'b0, 8'h00, 16'h0020);
        fetch(16'h0020, 16'h3333, 0);
        retire(1'b0, 12'h000, 1'b1, 8'hFE, 16'h001F);
        fetch(16'h001F, 16'h4444, 1);
        retire(1'b1, 12'h000, 1'b0, 8'h00, 16'h0000);
        fetch(16'h0000, 16'h5555, 0);
        retire(1'b0, 12'h000, 1'b1, 8'hFE, 16'hFFFF);
        fetch(16'hFFFF, 16'h6666, 0);

        for (int i = 0; i < 5; i++) begin
            m.i_data      = 16'h9000 | 16'(i);
            m.inputReady  = (i % 2 == 0);
            jump          = 1'b1;
            branch_taken  = 1'b1;
            jump_target   = 12'h123;
            tick();
            chk("hold_inst", inst, 16'h6666);
            chk("hold_pc", pc, 16'hFFFF);
            chk("hold_num", num_inst, 16'd6);
            chk("hold_readM", {15'd0, m.readM}, 16'd0);
            chk("hold_valid", {15'd0, inst_valid}, 16'd1);
        end
        m.inputReady = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        retire(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000);
        fetch(16'h0000, 16'h7777, 0);
        retire(1'b1, 12'h010, 1'b0, 8'h00, 16'h0010);

        p = 16'h0010;
        for (int k = 0; k < 96; k++) begin
            fetch(p, p ^ 16'hA5A5, k % 3);
            retire(1'b0, 12'h000, 1'b1, 8'h7F, p + 16'd128);
            p = p + 16'd128;
        end
        fetch(16'h3010, 16'hC0DE, 0);
        retire(1'b1, 12'h0AB, 1'b1, 8'h05, 16'h30AB);
        chk("jump_prio_addr", m.address, 16'h30AB);

        m.i_data     = 16'hBEEF;
        m.inputReady = 1'b1;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        m.inputReady = 1'b0;
        num_model    = 16'h0000;
        last_inst    = 16'h0000;
        chk("midrst_readM", {15'd0, m.readM}, 16'd0);
        chk("midrst_valid", {15'd0, inst_valid}, 16'd0);
        chk("midrst_inst", inst, 16'h0000);
        chk("midrst_pc", pc, 16'h0000);
        chk("midrst_num", num_inst, 16'h0000);
        tick();
        fetch(16'h0000, 16'h8888, 2);
        tick();
        tick();
        chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
